// File: rtl/audio_pkg.sv
// Shared definitions for the audio framing path.
//
// Contents:
//   SAMPLE_WIDTH   - bit width of one audio sample
//   DEF_WINDOW     - default samples per output frame
//   DEF_HOP        - default new samples between frame starts
//   DEF_DEPTH      - default circular buffer entries (power of two, >= 2*WINDOW)
//   framer_state_e - readout state machine encoding
package audio_pkg;

  localparam int unsigned SAMPLE_WIDTH = 16;
  localparam int unsigned DEF_WINDOW   = 1024;
  localparam int unsigned DEF_HOP      = 512;
  localparam int unsigned DEF_DEPTH    = 2048;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StStream
  } framer_state_e;

endpackage

// File: rtl/framer_ram.sv
// Simple dual-port sample buffer: one synchronous write port, one read port
// with a registered (1-cycle) read. No reset; contents survive framer reset.
//
// Ports:
//   clk     - clock, rising edge
//   wr_en   - write strobe
//   wr_addr - write address
//   wr_data - write data
//   rd_en   - read strobe; rd_data updates on the following edge
//   rd_addr - read address
//   rd_data - registered read data (old data on same-address collision)
module framer_ram #(
  parameter int unsigned DEPTH = 2048,
  parameter int unsigned WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/audio_framer.sv
// Overlapping-window audio framer. Incoming samples are written into a
// circular buffer continuously. Once WINDOW samples have arrived, every HOP-th
// sample triggers readout of the most recent WINDOW samples (oldest first) as
// a valid/ready stream. Triggers arriving while a frame is still being read
// out are dropped and flagged on a sticky overrun output.
//
// Ports:
//   clk_in          - clock, rising edge
//   rst_in          - asynchronous active-high reset
//   sample_in       - audio sample
//   sample_valid_in - single-cycle strobe qualifying sample_in
//   frame_data_out  - frame sample, oldest first
//   frame_valid_out - frame_data_out valid
//   frame_ready_in  - downstream accepts the current beat
//   frame_last_out  - current beat is the final sample of the frame
//   overrun_out     - sticky; a frame trigger was dropped
module audio_framer
  import audio_pkg::*;
#(
  parameter int unsigned WINDOW = DEF_WINDOW,
  parameter int unsigned HOP    = DEF_HOP,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                    sample_valid_in,
  output logic [SAMPLE_WIDTH-1:0] frame_data_out,
  output logic                    frame_valid_out,
  input  logic                    frame_ready_in,
  output logic                    frame_last_out,
  output logic                    overrun_out
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = $clog2(WINDOW + 1);
  localparam int unsigned HW = (HOP > 1) ? $clog2(HOP) : 1;

  localparam logic [PW-1:0] WinCount = PW'(WINDOW);
  localparam logic [PW-1:0] WinLast  = PW'(WINDOW - 1);
  localparam logic [HW-1:0] HopLast  = HW'(HOP - 1);
  localparam logic [AW-1:0] BackOff  = AW'(WINDOW - 1);

  // Write side
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [HW-1:0] hop_cnt_q, hop_cnt_d;
  logic [PW-1:0] prime_cnt_q, prime_cnt_d;
  logic          hop_wrap;
  logic          trigger;

  // Read side
  framer_state_e   state_q, state_d;
  logic [AW-1:0]   rd_addr_q, rd_addr_d;
  logic [PW-1:0]   rd_cnt_q, rd_cnt_d;
  logic            rd_issue;
  logic            issue_last;
  logic            reads_left;
  logic [SAMPLE_WIDTH-1:0] ram_rd_data;

  // Read pipeline: one RAM read in flight, then a two-entry output/skid pair
  logic                    rd_pend_q, rd_pend_last_q;
  logic                    skid_valid_q, skid_valid_d;
  logic [SAMPLE_WIDTH-1:0] skid_data_q, skid_data_d;
  logic                    skid_last_q, skid_last_d;
  logic                    out_valid_q, out_valid_d;
  logic [SAMPLE_WIDTH-1:0] out_data_q, out_data_d;
  logic                    out_last_q, out_last_d;
  logic                    overrun_q, overrun_d;
  logic                    pop;
  logic [1:0]              occ_after;
  logic                    room;

  // ---------------------------------------------------------------------------
  // Write side: pointer, hop counter, priming counter, trigger detect
  // ---------------------------------------------------------------------------
  assign hop_wrap = (hop_cnt_q == HopLast);
  // Primed after this write if WINDOW-1 samples were already stored.
  assign trigger  = sample_valid_in && hop_wrap && (prime_cnt_q >= WinLast);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    hop_cnt_d   = hop_cnt_q;
    prime_cnt_d = prime_cnt_q;
    if (sample_valid_in) begin
      wr_ptr_d  = wr_ptr_q + AW'(1);
      hop_cnt_d = hop_wrap ? '0 : hop_cnt_q + HW'(1);
      if (prime_cnt_q != WinCount) begin
        prime_cnt_d = prime_cnt_q + PW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Readout FSM and read address generation
  // ---------------------------------------------------------------------------
  assign pop        = out_valid_q && frame_ready_in;
  assign reads_left = (rd_cnt_q != WinCount);
  assign issue_last = (rd_cnt_q == WinLast);
  // Entries held or in flight once this cycle's pop retires; a new read may be
  // issued only if its data is guaranteed a slot when it returns.
  assign occ_after  = 2'(out_valid_q) + 2'(skid_valid_q) + 2'(rd_pend_q) - 2'(pop);
  assign room       = (occ_after <= 2'd1);

  always_comb begin
    state_d   = state_q;
    rd_issue  = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_cnt_d  = rd_cnt_q;
    overrun_d = overrun_q;

    unique case (state_q)
      StIdle: begin
        if (trigger) begin
          state_d   = StFetch;
          rd_addr_d = wr_ptr_q - BackOff;
          rd_cnt_d  = '0;
        end
      end
      StFetch: begin
        rd_issue = 1'b1;
        state_d  = StStream;
      end
      StStream: begin
        if (reads_left && room) begin
          rd_issue = 1'b1;
        end
        if (pop && out_last_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Any trigger outside IDLE (including one coinciding with the last beat)
    // is dropped.
    if (trigger && (state_q != StIdle)) begin
      overrun_d = 1'b1;
    end

    if (rd_issue) begin
      rd_addr_d = rd_addr_q + AW'(1);
      rd_cnt_d  = rd_cnt_q + PW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Output register with skid entry behind it
  // ---------------------------------------------------------------------------
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_last_d  = skid_last_q;

    if (!out_valid_q || pop) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_last_d   = skid_last_q;
        skid_valid_d = rd_pend_q;
        if (rd_pend_q) begin
          skid_data_d = ram_rd_data;
          skid_last_d = rd_pend_last_q;
        end
      end else begin
        out_valid_d = rd_pend_q;
        if (rd_pend_q) begin
          out_data_d = ram_rd_data;
          out_last_d = rd_pend_last_q;
        end else begin
          out_last_d = 1'b0;
        end
      end
    end else if (rd_pend_q) begin
      // Output is stalled; returning read data parks in the skid entry.
      skid_valid_d = 1'b1;
      skid_data_d  = ram_rd_data;
      skid_last_d  = rd_pend_last_q;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_q       <= '0;
      hop_cnt_q      <= '0;
      prime_cnt_q    <= '0;
      state_q        <= StIdle;
      rd_addr_q      <= '0;
      rd_cnt_q       <= '0;
      rd_pend_q      <= 1'b0;
      rd_pend_last_q <= 1'b0;
      skid_valid_q   <= 1'b0;
      skid_data_q    <= '0;
      skid_last_q    <= 1'b0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_last_q     <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      hop_cnt_q      <= hop_cnt_d;
      prime_cnt_q    <= prime_cnt_d;
      state_q        <= state_d;
      rd_addr_q      <= rd_addr_d;
      rd_cnt_q       <= rd_cnt_d;
      rd_pend_q      <= rd_issue;
      rd_pend_last_q <= rd_issue && issue_last;
      skid_valid_q   <= skid_valid_d;
      skid_data_q    <= skid_data_d;
      skid_last_q    <= skid_last_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      out_last_q     <= out_last_d;
      overrun_q      <= overrun_d;
    end
  end

  framer_ram #(
    .DEPTH (DEPTH),
    .WIDTH (SAMPLE_WIDTH)
  ) u_ram (
    .clk     (clk_in),
    .wr_en   (sample_valid_in),
    .wr_addr (wr_ptr_q),
    .wr_data (sample_in),
    .rd_en   (rd_issue),
    .rd_addr (rd_addr_q),
    .rd_data (ram_rd_data)
  );

  assign frame_data_out  = out_data_q;
  assign frame_valid_out = out_valid_q;
  assign frame_last_out  = out_last_q;
  assign overrun_out     = overrun_q;

endmodule

// File: tb/tb_audio_framer.sv
// Testbench for audio_framer. A scoreboard keeps every sample written since
// reset, applies the window/hop/overrun rules to build expected frames, and
// compares each accepted beat, stall stability, trigger latency and the
// overrun flag against it.
module tb_audio_framer;
  import audio_pkg::*;

  localparam int W = 1024;
  localparam int H = 512;
  localparam int D = 2048;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [15:0] sample_in;
  logic        sample_valid_in;
  logic [15:0] frame_data_out;
  logic        frame_valid_out;
  logic        frame_ready_in;
  logic        frame_last_out;
  logic        overrun_out;

  int total = 0;
  int bad   = 0;

  // Scoreboard state
  logic [15:0] hist[$];
  logic [15:0] exp_q[$];
  bit          m_ovr;
  bit          timing_armed;
  int          exp_start;
  int          cyc;
  bit          stall_prev;
  logic [15:0] stall_data;
  logic        stall_last;
  int          beat_in_frame;
  int          frames_done;
  bit          rdy_rand;

  audio_framer #(
    .WINDOW (W),
    .HOP    (H),
    .DEPTH  (D)
  ) u_dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .sample_in       (sample_in),
    .sample_valid_in (sample_valid_in),
    .frame_data_out  (frame_data_out),
    .frame_valid_out (frame_valid_out),
    .frame_ready_in  (frame_ready_in),
    .frame_last_out  (frame_last_out),
    .overrun_out     (overrun_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Samples inputs and outputs on the falling edge, i.e. the values the next
  // rising edge will act on.
  task automatic run_monitor();
    logic [15:0] exp_word;
    int          n;
    forever begin
      @(negedge clk_in);
      cyc++;
      if (rst_in) begin
        hist.delete();
        exp_q.delete();
        m_ovr         = 1'b0;
        timing_armed  = 1'b0;
        stall_prev    = 1'b0;
        beat_in_frame = 0;
      end else begin
        check("overrun", overrun_out, m_ovr);
        if (exp_q.size() == 0) check("idle_valid", frame_valid_out, 0);
        if (timing_armed) begin
          if (cyc < exp_start) begin
            check("early_valid", frame_valid_out, 0);
          end else begin
            check("valid_latency", frame_valid_out, 1);
            timing_armed = 1'b0;
          end
        end
        if (stall_prev) begin
          check("stall_valid", frame_valid_out, 1);
          check("stall_data", frame_data_out, stall_data);
          check("stall_last", frame_last_out, stall_last);
        end
        stall_prev = frame_valid_out && !frame_ready_in;
        stall_data = frame_data_out;
        stall_last = frame_last_out;

        // Trigger rule evaluated before the beat so a trigger on the final
        // beat still sees the frame as busy.
        if (sample_valid_in) begin
          hist.push_back(sample_in);
          n = hist.size();
          if ((n % H == 0) && (n >= W)) begin
            if (exp_q.size() != 0) begin
              m_ovr = 1'b1;
            end else begin
              for (int i = n - W; i < n; i++) exp_q.push_back(hist[i]);
              if (!rdy_rand) begin
                timing_armed = 1'b1;
                exp_start    = cyc + 3;
              end
            end
          end
        end

        if (frame_valid_out && frame_ready_in && (exp_q.size() != 0)) begin
          exp_word = exp_q.pop_front();
          check("beat_data", frame_data_out, exp_word);
          check("beat_last", frame_last_out, exp_q.size() == 0);
          beat_in_frame++;
          if (exp_q.size() == 0) begin
            frames_done++;
            beat_in_frame = 0;
          end
        end
      end
    end
  endtask

  task automatic run_ready();
    forever begin
      @(posedge clk_in);
      #1;
      if (rdy_rand) frame_ready_in = 1'($urandom_range(0, 1));
    end
  endtask

  // Called at posedge+1; leaves at posedge+1.
  task automatic apply_reset();
    rst_in          = 1'b1;
    sample_valid_in = 1'b0;
    sample_in       = '0;
    #1;
    check("rst_valid", frame_valid_out, 0);
    check("rst_last", frame_last_out, 0);
    check("rst_data", frame_data_out, 0);
    check("rst_overrun", overrun_out, 0);
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    @(posedge clk_in);
    #1;
  endtask

  task automatic send(input logic [15:0] v, input int gap);
    sample_in       = v;
    sample_valid_in = 1'b1;
    @(posedge clk_in);
    #1;
    sample_valid_in = 1'b0;
    repeat (gap - 1) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic drain(input int budget);
    for (int k = 0; k < budget && exp_q.size() != 0; k++) begin
      @(posedge clk_in);
      #1;
    end
    repeat (4) begin
      @(posedge clk_in);
      #1;
    end
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    int f0;
    bit got;
    rst_in          = 1'b0;
    sample_in       = '0;
    sample_valid_in = 1'b0;
    frame_ready_in  = 1'b1;
    rdy_rand        = 1'b0;
    cyc             = 0;
    frames_done     = 0;
    fork
      run_monitor();
      run_ready();
    join_none
    #2;

    // Priming and hop: 1536 index-valued samples, ready high
    apply_reset();
    f0 = frames_done;
    for (int i = 0; i < 1536; i++) send(16'(i), 4);
    drain(3000);
    check("frames_hop", frames_done - f0, 2);
    check("ovr_hop", overrun_out, 0);

    // Random backpressure with random data
    apply_reset();
    rdy_rand = 1'b1;
    f0 = frames_done;
    for (int i = 0; i < 2048; i++) send(16'($urandom), 6);
    drain(8000);
    rdy_rand       = 1'b0;
    frame_ready_in = 1'b1;
    check("frames_bp", frames_done - f0, 3);
    check("ovr_bp", overrun_out, 0);

    // Overrun: stall after the first beat, push one more hop
    apply_reset();
    f0 = frames_done;
    for (int i = 0; i < 1024; i++) send(16'(i + 100), 1);
    got = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk_in);
      if (frame_valid_out && frame_ready_in) begin
        got = 1'b1;
        break;
      end
    end
    check("first_beat", got, 1);
    @(posedge clk_in);
    #1;
    frame_ready_in = 1'b0;
    for (int i = 0; i < 512; i++) send(16'(i + 1124), 1);
    repeat (5) begin
      @(posedge clk_in);
      #1;
    end
    check("ovr_set", overrun_out, 1);
    frame_ready_in = 1'b1;
    drain(3000);
    check("frames_ovr", frames_done - f0, 1);
    check("ovr_sticky", overrun_out, 1);

    // Wrap-around of the circular buffer
    apply_reset();
    f0 = frames_done;
    for (int i = 0; i < 4608; i++) send(16'(i), 3);
    drain(3000);
    check("frames_wrap", frames_done - f0, 8);
    check("ovr_wrap", overrun_out, 0);

    // Reset in the middle of a frame
    apply_reset();
    for (int i = 0; i < 1024; i++) send(16'($urandom), 2);
    got = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk_in);
      if (beat_in_frame == 300) begin
        got = 1'b1;
        break;
      end
    end
    check("beat300", got, 1);
    @(posedge clk_in);
    #1;
    apply_reset();
    f0 = frames_done;
    for (int i = 0; i < 1023; i++) send(16'($urandom), 2);
    repeat (20) begin
      @(posedge clk_in);
      #1;
    end
    check("no_frame_unprimed", frames_done - f0, 0);
    check("valid_unprimed", frame_valid_out, 0);
    send(16'($urandom), 2);
    drain(3000);
    check("frames_after_rst", frames_done - f0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
